// File: rtl/dm_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_access_arbiter
// Brief    : Data-memory arbiter between the CPU MEM stage and a DMA master,
//            one fixed-latency read outstanding at a time.
// Revision : 1.0 - initial release
// ============================================================================
module dm_access_arbiter #(
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    input  logic        dma_req,
    input  logic [3:0]  dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [0:0] C_ST_IDLE      = 1'b0;
    localparam logic [0:0] C_ST_WAIT      = 1'b1;
    localparam logic       C_OWN_CPU      = 1'b0;
    localparam logic       C_OWN_DMA      = 1'b1;
    localparam logic [3:0] C_RD_LAT       = 4'(RD_LAT);
    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic [0:0]  state_q, state_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        owner_q, owner_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;
    logic        cpu_rvalid_q, cpu_rvalid_d;
    logic        dma_rvalid_q, dma_rvalid_d;

    logic        cpu_live;
    logic        dma_win;
    logic        cpu_win;
    logic        issue;
    logic [3:0]  iss_we;
    logic [31:0] iss_addr;
    logic [31:0] iss_wdata;

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        owner_d      = owner_q;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        cpu_rvalid_d = 1'b0;
        dma_rvalid_d = 1'b0;

        // The held cpu_req during the CPU's rvalid cycle is the tail of the
        // access that is completing, not a new request.
        cpu_live = cpu_req & ~cpu_rvalid_q;
        dma_win  = (state_q == C_ST_IDLE) & dma_req &
                   (~cpu_live | (starve_cnt_q == C_STARVE_LIMIT));
        cpu_win  = (state_q == C_ST_IDLE) & cpu_live & ~dma_win;
        issue    = dma_win | cpu_win;

        iss_we    = 4'b0;
        iss_addr  = 32'b0;
        iss_wdata = 32'b0;
        if (dma_win) begin
            iss_we    = dma_we;
            iss_addr  = dma_addr;
            iss_wdata = dma_wdata;
        end else if (cpu_win) begin
            iss_we    = cpu_we;
            iss_addr  = cpu_addr;
            iss_wdata = cpu_wdata;
        end

        if (issue && (iss_we == 4'b0)) begin
            owner_d   = dma_win ? C_OWN_DMA : C_OWN_CPU;
            lat_cnt_d = C_RD_LAT;
            state_d   = C_ST_WAIT;
        end

        if (state_q == C_ST_WAIT) begin
            lat_cnt_d = lat_cnt_q - 4'd1;
            if (lat_cnt_q == 4'd1) begin
                state_d = C_ST_IDLE;
                if (owner_q == C_OWN_DMA) begin
                    dma_rdata_d  = mem_rdata;
                    dma_rvalid_d = 1'b1;
                end else begin
                    cpu_rdata_d  = mem_rdata;
                    cpu_rvalid_d = 1'b1;
                end
            end
        end

        if (!dma_req || dma_win) begin
            starve_cnt_d = 4'd0;
        end else if (cpu_win && (starve_cnt_q != C_STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= C_ST_IDLE;
            lat_cnt_q    <= 4'd0;
            starve_cnt_q <= 4'd0;
            owner_q      <= C_OWN_CPU;
            cpu_rdata_q  <= 32'b0;
            dma_rdata_q  <= 32'b0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign mem_en     = issue & ~reset;
    assign mem_we     = reset ? 4'b0  : iss_we;
    assign mem_addr   = reset ? 32'b0 : iss_addr;
    assign mem_wdata  = reset ? 32'b0 : iss_wdata;
    assign dma_gnt    = dma_win & ~reset;
    assign cpu_stall  = ~reset & cpu_req & ~cpu_rvalid_q &
                        ~(cpu_win & (cpu_we != 4'b0));
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign dma_rvalid = dma_rvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_access_arbiter
// Brief    : Directed and randomized bench for dm_access_arbiter with a
//            cycle-numbered reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_access_arbiter;

    localparam int RD_LAT = 2;
    localparam int LIM    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_stall, cpu_rvalid;
    logic [3:0]  cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_gnt, dma_rvalid;
    logic [3:0]  dma_we;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dm_access_arbiter #(.RD_LAT(RD_LAT), .STARVE_LIMIT(LIM)) u_dut (
        .clk(clk), .reset(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a read issued in cycle iss delivers the mem_rdata seen
    // in cycle iss+RD_LAT, reported in cycle iss+RD_LAT+1.
    int          cyc = 0;
    bit          busy = 0;
    int          iss = 0;
    bit          own_dma = 0;
    int          starve = 0;
    logic [31:0] cap = 0, e_crd = 0, e_drd = 0;
    bit          m_stall = 0, m_gnt = 0;

    task automatic model_cycle();
        bit          rvc, rvd, live, dwin, cwin, stall, e_en;
        logic [3:0]  e_we;
        logic [31:0] e_addr, e_wd;
        rvc = 0; rvd = 0; dwin = 0; cwin = 0;
        if (busy && cyc == iss + RD_LAT) cap = mem_rdata;
        if (busy && cyc == iss + RD_LAT + 1) begin
            if (own_dma) begin rvd = 1; e_drd = cap; end
            else         begin rvc = 1; e_crd = cap; end
            busy = 0;
        end
        live = cpu_req && !rvc;
        if (!busy) begin
            if (dma_req && (!live || starve == LIM)) dwin = 1;
            else if (live)                           cwin = 1;
        end
        e_en = dwin || cwin; e_we = 0; e_addr = 0; e_wd = 0;
        if (dwin)      begin e_we = dma_we; e_addr = dma_addr; e_wd = dma_wdata; end
        else if (cwin) begin e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata; end
        stall = cpu_req && !(cwin && cpu_we != 0) && !rvc;
        check("m_en", mem_en, e_en);
        check("m_we", mem_we, e_we);
        check("m_addr", mem_addr, e_addr);
        check("m_wdata", mem_wdata, e_wd);
        check("m_stall", cpu_stall, stall);
        check("m_gnt", dma_gnt, dwin);
        check("m_crv", cpu_rvalid, rvc);
        check("m_drv", dma_rvalid, rvd);
        check("m_crd", cpu_rdata, e_crd);
        check("m_drd", dma_rdata, e_drd);
        if (!dma_req || dwin)       starve = 0;
        else if (cwin && starve < LIM) starve++;
        if (e_en && e_we == 0) begin busy = 1; iss = cyc; own_dma = dwin; end
        m_stall = stall;
        m_gnt   = dwin;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            busy = 0; starve = 0; e_crd = 0; e_drd = 0; m_stall = 0; m_gnt = 0;
            check("rst_ctl", {mem_en, mem_we, cpu_stall, dma_gnt, cpu_rvalid, dma_rvalid}, 0);
            check("rst_data", {cpu_rdata, dma_rdata}, 0);
        end else begin
            model_cycle();
        end
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        bit got;
        rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (2) @(posedge clk);

        // CPU read returning 0xDEADBEEF
        #1 cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("rd_en", mem_en, k == 0);
            check("rd_stall", cpu_stall, k < 3);
            check("rd_valid", cpu_rvalid, k == 3);
        end
        check("rd_data", cpu_rdata, 32'hDEADBEEF);

        // CPU byte write
        @(posedge clk); #1 cpu_req = 1; cpu_we = 4'b0011; cpu_addr = 32'h20; cpu_wdata = 32'h1234;
        @(negedge clk); #1;
        check("wr_en", mem_en, 1);
        check("wr_we", mem_we, 4'b0011);
        check("wr_addr", mem_addr, 32'h20);
        check("wr_stall", cpu_stall, 0);

        // Starvation: CPU writes back to back while a DMA read waits
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 4'hF; cpu_addr = 32'h100; cpu_wdata = $urandom;
        dma_req = 1; dma_we = 0; dma_addr = 32'h200; dma_wdata = 0; mem_rdata = 32'h5A5A_0F0F;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("stv_gnt", dma_gnt, k == 2);
            check("stv_stall", cpu_stall, k == 2);
            @(posedge clk); #1;
            if (k < 2) begin cpu_addr = cpu_addr + 32'd4; cpu_wdata = $urandom; end
            else dma_req = 0;
        end
        for (int k = 0; k < RD_LAT + 1; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            @(negedge clk); #1;
            check("dwait_stall", cpu_stall, k < RD_LAT);
            check("dwait_rv", dma_rvalid, k == RD_LAT);
            check("dwait_en", mem_en, k == RD_LAT);
        end
        check("dwait_data", dma_rdata, 32'h5A5A_0F0F);
        @(posedge clk); #1 cpu_req = 0;

        // Randomized traffic obeying the request-hold rules
        for (int i = 0; i < 1500; i++) begin
            int p_cpu, p_dma;
            p_cpu = (i < 500) ? 90 : (i < 1000) ? 30 : 60;
            p_dma = (i < 500) ? 70 : (i < 1000) ? 80 : 40;
            if (!m_stall) begin
                cpu_req   = ($urandom_range(0, 99) < p_cpu);
                cpu_we    = $urandom_range(0, 1) ? 4'($urandom) : 4'b0;
                cpu_addr  = $urandom;
                cpu_wdata = $urandom;
            end
            if (!(dma_req && !m_gnt)) begin
                dma_req   = ($urandom_range(0, 99) < p_dma);
                dma_we    = $urandom_range(0, 1) ? 4'($urandom) : 4'b0;
                dma_addr  = $urandom;
                dma_wdata = $urandom;
            end
            mem_rdata = $urandom;
            @(posedge clk); #1;
        end
        cpu_req = 0; dma_req = 0;
        repeat (RD_LAT + 3) @(posedge clk);

        // Reset asserted while a CPU read is outstanding
        #1 cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40; mem_rdata = 32'h1111_2222;
        @(negedge clk); #1 check("rw_issue", mem_en, 1);
        @(posedge clk); #3 rst = 1;
        #1;
        check("rw_async_ctl", {mem_en, cpu_stall, cpu_rvalid, dma_gnt}, 0);
        check("rw_async_data", cpu_rdata, 0);
        cpu_req = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        for (int k = 0; k < RD_LAT + 3; k++) begin
            @(negedge clk); #1 check("rw_no_rv", cpu_rvalid, 0);
        end
        @(posedge clk); #1 cpu_req = 1; cpu_we = 0; cpu_addr = 32'h44; mem_rdata = 32'hCAFE_0001;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk); #1;
            if (cpu_rvalid) got = 1;
        end
        check("rw_done", got, 1);
        check("rw_data", cpu_rdata, 32'hCAFE_0001);
        @(posedge clk); #1 cpu_req = 0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
